mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  MEM stage of the 5-stage MIPS pipeline; consumes the EX/MEM register outputs of the Execute stage.
//  Resolves branch (pcsrc) and does word loads/stores on an internal data memory of fixed latency.
//  Stalls upstream while an access is in flight; drives the MEM/WB register for Writeback.
// PARAMETERS
//  ADDR_W   8   word-address width; memory holds 2**ADDR_W 32-bit words
//  MEM_LAT  3   load/store latency in clock edges, >=1 (1 = single-cycle memory)
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  in_valid       in   1   EX/MEM holds a valid instruction
//  wb_ctl         in   2   writeback controls {regwrite, memtoreg}
//  branch         in   1   instruction is a branch
//  memread        in   1   load
//  memwrite       in   1   store
//  zero           in   1   ALU zero flag
//  alu_result     in   32  ALU result / byte address
//  rdata2         in   32  store data
//  write_reg      in   5   destination register number
//  ex_mem_npc     in   32  branch target from EX adder
//  stall          out  1   upstream must hold EX/MEM contents
//  pcsrc          out  1   take branch
//  branch_target  out  32  = ex_mem_npc
//  out_valid      out  1   MEM/WB holds a newly completed instruction (1-cycle pulse)
//  mem_wb_ctl     out  2   registered wb_ctl
//  read_data      out  32  registered load data
//  mem_alu_result out  32  registered alu_result
//  mem_write_reg  out  5   registered write_reg
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, stall=0, out_valid=0, mem_wb_ctl/read_data/mem_alu_result/mem_write_reg=0.
//   Memory array is not reset.
//  Addressing: word index = alu_result[ADDR_W+1:2]; bits [1:0] and bits above ADDR_W+1 ignored (alias/wrap).
//  FSM states IDLE, BUSY. stall = (state==BUSY), combinational from state.
//  IDLE, in_valid=0: out_valid<=0, MEM/WB regs hold.
//  IDLE, in_valid=1, no mem op: MEM/WB regs load at this edge, read_data holds, out_valid<=1. Latency 1.
//  IDLE, in_valid=1, mem op, MEM_LAT=1: access completes at this edge (as completion below).
//  IDLE, in_valid=1, mem op, MEM_LAT>1: latch all inputs, cnt<=MEM_LAT-1, ->BUSY, out_valid<=0.
//  BUSY: inputs ignored; cnt decrements each edge; on edge with cnt==1 -> completion, ->IDLE.
//   stall is high for exactly MEM_LAT-1 cycles; next instruction accepted the cycle after stall falls.
//  Completion edge: store writes mem[idx]<=rdata2; load read_data<=mem[idx]; MEM/WB regs load; out_valid<=1.
//   Memory write occurs only on the completion edge.
//  memread & memwrite both 1: treated as store; read_data holds.
//  pcsrc = in_valid & (state==IDLE) & branch & zero, combinational; branch_target = ex_mem_npc always.
//   branch with memread/memwrite is not produced by decode; behaviour unspecified.
//  Reset mid-access: FSM->IDLE, pending op discarded, no memory write, all outputs to reset values.
//  In-order, single-issue: at most one instruction in flight.
// TESTING
//  1 MEM_LAT=3; store alu_result=0x10 rdata2=0xDEADBEEF -> stall=1 for 2 cycles, out_valid pulse on 3rd edge.
//  2 Then load 0x10, wb_ctl=2'b11, write_reg=9 -> read_data=0xDEADBEEF, mem_wb_ctl=2'b11, mem_write_reg=9.
//  3 R-type alu_result=0x1234 write_reg=7 wb_ctl=2'b10 -> next edge outputs match, out_valid=1, stall=0.
//  4 branch=1 zero=1 ex_mem_npc=0x40 -> pcsrc=1, branch_target=0x40 same cycle; zero=0 -> pcsrc=0.
//  5 rst_n low during BUSY of store 0xCAFE to 0x20 -> stall=0 out_valid=0; later load 0x20 returns prior value.
//  6 ADDR_W=8: store 0x55 at alu_result=0x400, load 0x000 -> read_data=0x55 (wrap); MEM_LAT=1 -> no stall.

Source files
------------

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MIPS MEM stage: branch resolve, fixed-latency word load/store, MEM/WB register
module mem_access_stage #(
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  input  logic [1:0]  wb_ctl_i,
  input  logic        branch_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic        zero_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] rdata2_i,
  input  logic [4:0]  write_reg_i,
  input  logic [31:0] ex_mem_npc_i,
  output logic        stall_o,
  output logic        pcsrc_o,
  output logic [31:0] branch_target_o,
  output logic        out_valid_o,
  output logic [1:0]  mem_wb_ctl_o,
  output logic [31:0] read_data_o,
  output logic [31:0] mem_alu_result_o,
  output logic [4:0]  mem_write_reg_o
);

  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

  localparam int               CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic             MULTI  = (MEM_LAT > 1);

  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Instruction captured at acceptance, used while the access is in flight
  logic [1:0]  ctl_q;
  logic        rd_q, wr_q;
  logic [31:0] alu_q, wdata_q;
  logic [4:0]  wreg_q;

  logic        out_valid_q;
  logic [1:0]  mem_wb_ctl_q;
  logic [31:0] read_data_q, mem_alu_result_q;
  logic [4:0]  mem_write_reg_q;

  logic [31:0] mem_q [2**ADDR_W];

  logic              busy, accept, start_wait, complete, mem_we, load_en;
  logic [1:0]        sel_ctl;
  logic              sel_rd, sel_wr;
  logic [31:0]       sel_alu, sel_wdata;
  logic [4:0]        sel_wreg;
  logic [ADDR_W-1:0] sel_idx;

  always_comb begin
    busy       = (state_q == BUSY);
    accept     = in_valid_i & ~busy;
    sel_ctl    = busy ? ctl_q   : wb_ctl_i;
    sel_rd     = busy ? rd_q    : memread_i;
    sel_wr     = busy ? wr_q    : memwrite_i;
    sel_alu    = busy ? alu_q   : alu_result_i;
    sel_wdata  = busy ? wdata_q : rdata2_i;
    sel_wreg   = busy ? wreg_q  : write_reg_i;
    sel_idx    = sel_alu[ADDR_W+1:2];
    start_wait = accept & (sel_rd | sel_wr) & MULTI;
    complete   = (accept & ~start_wait) | (busy & (cnt_q == CNT_ONE));
    // A store wins over a simultaneous load; no write while reset is held
    mem_we     = complete & sel_wr & rst_ni;
    load_en    = complete & sel_rd & ~sel_wr;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (start_wait) begin
      state_d = BUSY;
      cnt_d   = LAT_M1;
    end else if (busy) begin
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctl_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      alu_q   <= '0;
      wdata_q <= '0;
      wreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        ctl_q   <= wb_ctl_i;
        rd_q    <= memread_i;
        wr_q    <= memwrite_i;
        alu_q   <= alu_result_i;
        wdata_q <= rdata2_i;
        wreg_q  <= write_reg_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q      <= 1'b0;
      mem_wb_ctl_q     <= '0;
      read_data_q      <= '0;
      mem_alu_result_q <= '0;
      mem_write_reg_q  <= '0;
    end else begin
      out_valid_q <= complete;
      if (complete) begin
        mem_wb_ctl_q     <= sel_ctl;
        mem_alu_result_q <= sel_alu;
        mem_write_reg_q  <= sel_wreg;
      end
      if (load_en) read_data_q <= mem_q[sel_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[sel_idx] <= sel_wdata;
  end

  assign stall_o          = busy;
  assign pcsrc_o          = in_valid_i & ~busy & branch_i & zero_i;
  assign branch_target_o  = ex_mem_npc_i;
  assign out_valid_o      = out_valid_q;
  assign mem_wb_ctl_o     = mem_wb_ctl_q;
  assign read_data_o      = read_data_q;
  assign mem_alu_result_o = mem_alu_result_q;
  assign mem_write_reg_o  = mem_write_reg_q;

endmodule
